mux4_rr_sel_stage: RTL and testbench
====================================

// Module: mux4_rr_sel_stage
// PURPOSE
//  Control and capture stage wrapped around mux4_1_4bit. Arbitrates round-robin among four
//  requesters and drives the mux select S. Captures the mux Out into an output register
//  with a valid/ready handshake toward the consumer. Sits on both sides of the mux:
//  upstream of its S input and downstream of its Out output.
// PARAMETERS
//  WIDTH  4  data width of mux_out / out_data (matches mux4_1_4bit)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-low reset (0 = reset)
//  req        in   4      req[i]=1: requester i's data is present on mux input i
//  gnt        out  4      one-hot; gnt[i]=1: mux input i captured this cycle
//  sel        out  2      drives mux4_1_4bit S (0=InA, 1=InB, 2=InC, 3=InD)
//  mux_out    in   WIDTH  mux4_1_4bit Out
//  out_valid  out  1      out_data holds an unconsumed word
//  out_ready  in   1      consumer accepts out_data this cycle
//  out_data   out  WIDTH  registered captured word
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0, out_data=0, last_sel=0, ptr=3. The first priority
//    is therefore requester 0. gnt=0 while in reset.
//  - load = (|req) & (~out_valid | out_ready). This is a combinational accept condition.
//  - Winner: the first i with req[i]=1, searched in order ptr+1, ptr+2, ptr+3, ptr (mod 4,
//    wraps 3->0).
//  - sel = winner when |req, else last_sel. The path is combinational, so the mux settles
//    in the same cycle.
//  - gnt[winner] = load. gnt is combinational, one cycle per accepted word, never more than
//    one bit set.
//  - Clock edge with load=1:
//      out_data <= mux_out
//      out_valid <= 1
//      ptr <= winner
//      last_sel <= winner
//  - Clock edge with load=0 and out_valid & out_ready: out_valid <= 0, and out_data holds.
//  - Clock edge with out_valid & ~out_ready: all state holds. out_data is stable and no gnt
//    is asserted (backpressure).
//  - Simultaneous drain and fill (out_valid & out_ready & |req): the new word replaces the
//    old one and out_valid stays 1. Throughput is 1 word/cycle and latency is 1 cycle from
//    gnt to out_valid.
//  - Requester contract: hold req[i] and its mux input stable until gnt[i]. req may drop
//    without a grant and is then simply skipped.
//  - ptr advances only on a grant. A lone requester is granted on every accept cycle.
//  - Two-state FSM implied by out_valid:
//      EMPTY -> FULL on load
//      FULL -> FULL on load, or on ~out_ready
//      FULL -> EMPTY on out_ready & ~|req
//  - Reset mid-operation drops any held word: out_valid goes to 0 immediately (async). The
//    in-flight gnt is deasserted and arbitration restarts at priority 0.
//  - No X on any output after reset. No combinational path from out_ready to sel.
// TESTING
//  (Bench instantiates mux4_1_4bit with mux inputs driven by the bench; sel->S, Out->mux_out.)
//  1 Reset: rst=0 with random req/mux inputs.
//    -> out_valid=0, out_data=0, gnt=0, sel=0.
//  2 Round-robin: req=4'b1111, InA..InD=1,8,A,5, out_ready=1.
//    -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; out_data 1,8,A,5,1 one cycle later.
//  3 Backpressure: full with out_data=8, out_ready=0 for 3 cycles, req=4'b1111.
//    -> out_data stays 8, gnt=0; the first cycle after out_ready=1 grants the next index.
//  4 Skip/wrap: ptr=2, req=4'b0011.
//    -> gnt=0001 then 0010.
//    req=4'b0100 alone -> gnt=0100 on every accept cycle, sel=2.
//  5 Drain: one word held, then req=0 and out_ready=1.
//    -> out_valid=0 next cycle, out_data unchanged, sel=last_sel.
//  6 Reset mid-stream: during test 2, pulse rst=0 for 1 cycle.
//    -> out_valid drops at once; after release the first grant is gnt=0001.
//  Random phase: $random on req, mux inputs and out_ready for 3000 cycles. Scoreboard checks:
//    - out_data equals the granted input
//    - every grant is one-hot
//    - no requester waits more than 4 accept cycles

Source files
------------

// File: rtl/mux4_rr_sel_stage_if.sv
// Bundle between the round-robin select/capture stage and its environment.
// master = the stage itself; slave = requesters, mux and consumer side.
interface mux4_rr_sel_stage_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] mux_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  req,
    input  mux_out,
    input  out_ready,
    output gnt,
    output sel,
    output out_valid,
    output out_data
  );

  modport slave (
    output req,
    output mux_out,
    output out_ready,
    input  gnt,
    input  sel,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/mux4_rr_sel_stage.sv
// Round-robin select stage around a 4:1 mux: picks a requester, steers the mux
// and captures its output into a one-deep valid/ready output register.
module mux4_1_4bit (
  input  logic [3:0] InA,
  input  logic [3:0] InB,
  input  logic [3:0] InC,
  input  logic [3:0] InD,
  input  logic [1:0] S,
  output logic [3:0] Out
);
  always_comb begin
    case (S)
      2'd0:    Out = InA;
      2'd1:    Out = InB;
      2'd2:    Out = InC;
      default: Out = InD;
    endcase
  end
endmodule

module mux4_rr_sel_stage #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux4_rr_sel_stage_if.master bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       ptr_reg;
  logic [1:0]       last_sel_reg;
  logic [WIDTH-1:0] out_data_reg;

  logic       any_req;
  logic       load;
  logic       out_valid;
  logic [1:0] winner;
  logic       found;

  assign any_req = |bus.req;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    winner = ptr_reg;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.req[ptr_reg + 2'(k)]) begin
        winner = ptr_reg + 2'(k);
        found  = 1'b1;
      end
    end
  end

  // Next-state and accept logic; rst gating keeps gnt quiet while reset is held.
  always_comb begin
    state_next = state_reg;
    out_valid  = (state_reg == FULL);
    load       = rst && any_req && (!out_valid || bus.out_ready);
    case (state_reg)
      EMPTY: begin
        if (load) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (!load && bus.out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= EMPTY;
      ptr_reg      <= 2'd3;
      last_sel_reg <= 2'd0;
      out_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        out_data_reg <= bus.mux_out;
        ptr_reg      <= winner;
        last_sel_reg <= winner;
      end
    end
  end

  // Select depends only on req and state, never on out_ready.
  assign bus.sel = !rst ? 2'd0 : (any_req ? winner : last_sel_reg);

  for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
    assign bus.gnt[gi] = load && (winner == 2'(gi));
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_reg;

endmodule

// File: tb/tb_mux4_rr_sel_stage.sv
// Directed and constrained-random checks of the round-robin select/capture stage
// together with the 4:1 mux it steers.
module tb_mux4_rr_sel_stage;

  logic       clk;
  logic       rst;
  logic [3:0] din [4];
  int         checks;
  int         errors;

  mux4_rr_sel_stage_if #(.WIDTH(4)) bus ();

  mux4_rr_sel_stage #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mux4_1_4bit u_mux (
    .InA (din[0]),
    .InB (din[1]),
    .InC (din[2]),
    .InD (din[3]),
    .S   (bus.sel),
    .Out (bus.mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.req       = 4'($urandom);
    bus.out_ready = 1'($urandom);
    for (int i = 0; i < 4; i++) din[i] = 4'($urandom);
    #3;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
      checks++;
      if (bus.out_data !== 4'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data); end
      checks++;
      if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
      checks++;
      if (bus.sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", bus.sel); end
      $display("reset cycle %0d req=%b valid=%b data=%h gnt=%b sel=%0d", c, bus.req, bus.out_valid, bus.out_data, bus.gnt, bus.sel);
      tick();
      bus.req = 4'($urandom);
    end
    bus.req = 4'b0000;
    rst     = 1'b1;
    #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    din[0] = 4'h1; din[1] = 4'h8; din[2] = 4'hA; din[3] = 4'h5;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_g = 4'b0001 << (i % 4);
      checks++;
      if (bus.gnt !== exp_g) begin errors++; $display("FAIL rr_gnt step %0d got %b want %b", i, bus.gnt, exp_g); end
      checks++;
      if (bus.sel !== 2'(i % 4)) begin errors++; $display("FAIL rr_sel step %0d got %0d want %0d", i, bus.sel, i % 4); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== din[i % 4]) begin
        errors++; $display("FAIL rr_data step %0d got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, din[i % 4]);
      end
      $display("rr step %0d gnt=%b out_data=%h", i, exp_g, bus.out_data);
    end
  endtask

  task automatic test_backpressure();
    // Previous winner was 0, so this accept grants 1 (data 8).
    #1;
    checks++;
    if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL bp_fill_gnt got %b want 0010", bus.gnt); end
    tick();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt cycle %0d got %b want 0000", c, bus.gnt); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h8) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b d=%h want v=1 d=8", c, bus.out_valid, bus.out_data);
      end
      $display("bp cycle %0d stalled out_data=%h", c, bus.out_data);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL bp_release_gnt got %b want 0100", bus.gnt); end
    tick();
    checks++;
    if (bus.out_data !== 4'hA) begin errors++; $display("FAIL bp_release_data got %h want a", bus.out_data); end
    $display("bp release gnt=0100 out_data=%h", bus.out_data);
  endtask

  task automatic test_skip_wrap();
    logic [3:0] exp_seq [2];
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    // ptr is 2 here; search order 3,0,1,2.
    bus.req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.gnt !== exp_seq[i]) begin errors++; $display("FAIL skip_gnt step %0d got %b want %b", i, bus.gnt, exp_seq[i]); end
      tick();
      checks++;
      if (bus.out_data !== din[i]) begin errors++; $display("FAIL skip_data step %0d got %h want %h", i, bus.out_data, din[i]); end
      $display("skip step %0d gnt=%b out_data=%h", i, exp_seq[i], bus.out_data);
    end
    bus.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2) begin
        errors++; $display("FAIL lone_gnt step %0d got gnt=%b sel=%0d want 0100/2", i, bus.gnt, bus.sel);
      end
      tick();
      $display("lone step %0d gnt=0100 out_data=%h", i, bus.out_data);
    end
  endtask

  task automatic test_drain();
    bus.req = 4'b0000;
    din[2]  = 4'h3;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.sel !== 2'd2) begin
      errors++; $display("FAIL drain_comb got gnt=%b sel=%0d want 0000/2", bus.gnt, bus.sel);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'hA) begin
      errors++; $display("FAIL drain_state got v=%b d=%h want v=0 d=a", bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.sel !== 2'd2) begin errors++; $display("FAIL drain_sel got %0d want 2", bus.sel); end
    $display("drain out_valid=%b out_data=%h sel=%0d", bus.out_valid, bus.out_data, bus.sel);
  endtask

  task automatic test_reset_midstream();
    din[0] = 4'h1; din[1] = 4'h8; din[2] = 4'hA; din[3] = 4'h5;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.gnt !== 4'b0000) begin
      errors++; $display("FAIL midrst_async got v=%b gnt=%b want 0/0000", bus.out_valid, bus.gnt);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
      errors++; $display("FAIL midrst_first_gnt got gnt=%b sel=%0d want 0001/0", bus.gnt, bus.sel);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h1) begin
      errors++; $display("FAIL midrst_data got v=%b d=%h want 1/1", bus.out_valid, bus.out_data);
    end
    $display("midrst restart gnt=0001 out_data=%h", bus.out_data);
  endtask

  task automatic test_random();
    logic [3:0] pending;
    logic       m_valid;
    logic [3:0] m_data;
    logic [1:0] m_ptr;
    logic [1:0] m_last;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       ld;
    logic [3:0] exp_g;
    logic [1:0] exp_sel;
    int         wait_cnt [4];

    bus.req = 4'b0000;
    rst     = 1'b0;
    #2;
    rst     = 1'b1;
    tick();
    pending = 4'b0000;
    m_valid = 1'b0; m_data = 4'h0; m_ptr = 2'd3; m_last = 2'd0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pending[i]) begin
          din[i] = 4'($urandom);
          if ($urandom_range(0, 2) == 0) pending[i] = 1'b1;
        end
      end
      bus.req       = pending;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      win   = m_ptr;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        idx = m_ptr + 2'(k);
        if (!found && pending[idx]) begin win = idx; found = 1'b1; end
      end
      ld      = (|pending) && (!m_valid || bus.out_ready);
      exp_g   = ld ? (4'b0001 << win) : 4'b0000;
      exp_sel = (|pending) ? win : m_last;
      checks++;
      if ($countones(bus.gnt) > 1) begin errors++; $display("FAIL rnd_onehot cycle %0d got %b want at most one bit", c, bus.gnt); end
      checks++;
      if (bus.gnt !== exp_g) begin errors++; $display("FAIL rnd_gnt cycle %0d got %b want %b", c, bus.gnt, exp_g); end
      checks++;
      if (bus.sel !== exp_sel) begin errors++; $display("FAIL rnd_sel cycle %0d got %0d want %0d", c, bus.sel, exp_sel); end
      if (ld) begin
        for (int i = 0; i < 4; i++) begin
          if (pending[i] && 2'(i) != win) begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] > 4) begin errors++; $display("FAIL rnd_starve req %0d waited %0d want <=4", i, wait_cnt[i]); end
          end
        end
        wait_cnt[win] = 0;
        m_valid = 1'b1;
        m_data  = din[win];
        m_ptr   = win;
        m_last  = win;
        pending[win] = 1'b0;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
      tick();
      checks++;
      if (bus.out_valid !== m_valid || (m_valid && bus.out_data !== m_data)) begin
        errors++; $display("FAIL rnd_out cycle %0d got v=%b d=%h want v=%b d=%h", c, bus.out_valid, bus.out_data, m_valid, m_data);
      end
      if (ld) $display("rnd cycle %0d grant %0d data=%h", c, win, m_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_drain();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
